// File: rtl/audio_pkg.sv
// Shared audio-path types: sample width, stereo pair struct and serial format selector.
package audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 16;

  typedef struct packed {
    logic signed [AUDIO_SAMPLE_WIDTH-1:0] left;
    logic signed [AUDIO_SAMPLE_WIDTH-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } audio_fmt_t;

  function automatic audio_fmt_t fmt_from_mode(input int i2s_mode);
    return (i2s_mode != 0) ? FMT_I2S : FMT_LJ;
  endfunction

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Stereo sample handshake between the effects chain (master) and the DAC serializer (slave).
interface audio_dac_serializer_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
) ();

  logic signed [SAMPLE_WIDTH-1:0] leftSampleIn;
  logic signed [SAMPLE_WIDTH-1:0] rightSampleIn;
  logic                           sampleValid;
  logic                           sampleReady;

  modport master (
    output leftSampleIn,
    output rightSampleIn,
    output sampleValid,
    input  sampleReady
  );

  modport slave (
    input  leftSampleIn,
    input  rightSampleIn,
    input  sampleValid,
    output sampleReady
  );

endinterface

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: toggles the codec BCLK every BCLK_DIV system clocks and
// flags the cycle whose closing edge produces a rise or a fall.
module audio_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic dacBclk,
  output logic bclkRise,
  output logic bclkFall
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          term;

  assign term = (div_cnt_q == TERM);

  always_comb begin
    div_cnt_d = div_cnt_q + CW'(1);
    bclk_d    = bclk_q;
    if (term) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // Strobes are valid in the cycle before the edge that changes dacBclk.
  assign dacBclk  = bclk_q;
  assign bclkRise = term & ~bclk_q;
  assign bclkFall = term &  bclk_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// Stereo DAC serializer: one-entry sample buffer feeding an I2S or left-justified
// BCLK/LRCK/DATA stream, with frame-start and underrun pulses.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SLOT_BITS    = 16,
  parameter int BCLK_DIV     = 4,
  parameter int I2S_MODE     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  audio_dac_serializer_if.slave samp_if,
  output logic                  dacBclk,
  output logic                  dacLrck,
  output logic                  dacData,
  output logic                  frameStart,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int PAD_BITS   = SLOT_BITS - SAMPLE_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam audio_fmt_t FMT = fmt_from_mode(I2S_MODE);

  logic bclk_fall;
  logic bclk_rise_unused;

  audio_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk (
    .clk      (clk),
    .reset_n  (reset_n),
    .dacBclk  (dacBclk),
    .bclkRise (bclk_rise_unused),
    .bclkFall (bclk_fall)
  );

  logic                    buf_full_q, buf_full_d;
  logic [SAMPLE_WIDTH-1:0] buf_left_q, buf_left_d;
  logic [SAMPLE_WIDTH-1:0] buf_right_q, buf_right_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    delay_q, delay_d;
  logic                    lrck_q, lrck_d;
  logic                    data_q, data_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;

  logic                    xfer;
  logic [CNT_W-1:0]        new_cnt;
  logic [SLOT_BITS-1:0]    left_slot, right_slot;
  logic                    tx_bit;

  assign samp_if.sampleReady = reset_n & ~buf_full_q;
  assign xfer = samp_if.sampleValid & samp_if.sampleReady;

  // Samples sit in the slot MSBs; any spare slot bits are zero.
  assign left_slot  = SLOT_BITS'(buf_left_q)  << PAD_BITS;
  assign right_slot = SLOT_BITS'(buf_right_q) << PAD_BITS;
  assign new_cnt    = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);

  always_comb begin
    buf_full_d    = buf_full_q;
    buf_left_d    = buf_left_q;
    buf_right_d   = buf_right_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    delay_d       = delay_q;
    lrck_d        = lrck_q;
    data_d        = data_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    tx_bit        = 1'b0;

    if (bclk_fall) begin
      bit_cnt_d = new_cnt;
      if (bit_cnt_q == LAST_BIT) begin
        shift_d       = buf_full_q ? {left_slot, right_slot} : '0;
        buf_full_d    = 1'b0;
        frame_start_d = 1'b1;
        underrun_d    = ~buf_full_q;
      end
      tx_bit = shift_d[LAST_BIT - new_cnt];
      lrck_d = (new_cnt >= CNT_W'(SLOT_BITS));
      if (FMT == FMT_LJ) begin
        data_d = tx_bit;
      end else begin
        // I2S lags the word clock by one BCLK.
        data_d  = delay_q;
        delay_d = tx_bit;
      end
    end

    // A load on this same edge has already seen the old (empty) buffer.
    if (xfer) begin
      buf_full_d  = 1'b1;
      buf_left_d  = samp_if.leftSampleIn;
      buf_right_d = samp_if.rightSampleIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_full_q    <= 1'b0;
      buf_left_q    <= '0;
      buf_right_q   <= '0;
      bit_cnt_q     <= LAST_BIT;
      shift_q       <= '0;
      delay_q       <= 1'b0;
      lrck_q        <= 1'b0;
      data_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      buf_full_q    <= buf_full_d;
      buf_left_q    <= buf_left_d;
      buf_right_q   <= buf_right_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      delay_q       <= delay_d;
      lrck_q        <= lrck_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign dacLrck    = lrck_q;
  assign dacData    = data_q;
  assign frameStart = frame_start_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Transmit end of the stereo sample path. It takes processed 16-bit left/right samples from the effects chain, for example the distortion stage output.
- It serialises the samples to the audio codec DAC as a bit-clock/word-clock/data stream, in I2S or left-justified format.
- It contains a one-entry holding buffer with a valid/ready handshake, and flags underrun when the chain misses a frame.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel sample, two's complement.
- SLOT_BITS, 16: BCLK periods per channel slot; must be >= SAMPLE_WIDTH.
- BCLK_DIV, 4: system clocks per BCLK half-period; must be >= 1.
- I2S_MODE, 1: 1 = I2S (data one BCLK after LRCK edge); 0 = left-justified.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- leftSampleIn  in  SAMPLE_WIDTH  left sample, signed.
- rightSampleIn  in  SAMPLE_WIDTH  right sample, signed.
- sampleValid  in  1  producer offers a stereo pair.
- sampleReady  out  1  block can accept a pair this cycle.
- dacBclk  out  1  codec bit clock.
- dacLrck  out  1  word clock; 0 = left slot, 1 = right slot.
- dacData  out  1  serial data, MSB first.
- frameStart  out  1  one-clk pulse when a frame word is loaded.
- underrun  out  1  one-clk pulse when a frame is loaded with the buffer empty.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on reset_n. All state is updated on the rising edge of clk.
- Reset values:
  - dacBclk = 0, dacLrck = 0, dacData = 0.
  - frameStart = 0, underrun = 0.
  - Divider counter = 0. bitCnt = 2*SLOT_BITS-1.
  - Buffer empty. Shift word = 0. Delay bit = 0.
  - sampleReady forced 0 while reset_n is low.
- BCLK generation:
  - divCnt counts 0..BCLK_DIV-1. At terminal count, dacBclk toggles and divCnt wraps.
  - A toggle 0->1 is a rise strobe; a toggle 1->0 is a fall strobe.
  - BCLK period = 2*BCLK_DIV clocks. The first rise is BCLK_DIV clocks after reset release; the first fall is 2*BCLK_DIV clocks after.
- Bit counter: on each fall strobe, bitCnt increments modulo 2*SLOT_BITS. All serial outputs change only on fall strobes; the codec samples on BCLK rise.
- Frame load, on the fall strobe where bitCnt wraps to 0:
  - Buffer full: shift word = {left, zero-pad to SLOT_BITS, right, zero-pad to SLOT_BITS}; buffer is cleared.
  - Buffer empty: shift word = all zeros; underrun pulses.
  - frameStart pulses in both cases.
  - The first frame start occurs 2*BCLK_DIV clocks after reset release. The buffer is empty then, so underrun pulses on that load.
- Outputs on each fall strobe:
  - dacLrck = (new bitCnt >= SLOT_BITS).
  - Left-justified: dacData = shift word bit (2*SLOT_BITS-1-bitCnt).
  - I2S: dacData = the previously transmitted frame bit, via a one-bit delay register. The right-channel LSB of frame N therefore appears at bitCnt 0 of frame N+1.
- Handshake:
  - sampleReady = reset_n & buffer empty. This is combinational from registered state.
  - Transfer occurs when sampleValid & sampleReady at a clk edge: the buffer captures both inputs and becomes full.
  - If a transfer and a frame load occur on the same edge, the load uses the previous (empty) buffer state: the frame is zeros and underrun pulses. The captured pair waits for the next frame.
  - Inputs are ignored while sampleReady is 0. No data is lost; the producer must hold sampleValid.
- Reset mid-frame: all state returns to reset values on the next edge. The partial frame is abandoned, dacBclk goes low, and the buffer is emptied.
- Arithmetic: samples are not modified. Only bit placement and zero padding in the slot LSBs.

Decomposition:
- audio_pkg holds:
  - AUDIO_SAMPLE_WIDTH = 16.
  - typedef stereo_sample_t, a struct of signed left/right.
  - Enum audio_fmt_t: FMT_I2S, FMT_LJ.
- Sub-module audio_bclk_gen: the divider. It outputs dacBclk plus bclkRise/bclkFall strobes, and is reused by the ADC deserialiser.

Test Plan:
- Reset release, sampleValid = 0, BCLK_DIV = 2, SLOT_BITS = 16 -> dacBclk period is 4 clks. frameStart and underrun pulse every 128 clks, the first at clk 4. dacData stays 0.
- Push left = 16'h8001, right = 16'h7FFE before a frame start, I2S -> after the LRCK falling edge, one BCLK of the previous bit (0), then bits 1000000000000001 on left. LRCK high for right, carrying 0111111111111110 delayed one BCLK. No underrun on that frame.
- Same pair, I2S_MODE = 0 -> MSB of left coincides with the first BCLK after the LRCK falling edge; right MSB with the LRCK rising edge.
- Hold sampleValid high continuously -> sampleReady drops after the first accept and rises for one cycle after each frame load. Exactly one pair is accepted per 128 clks. The accepted sequence 1, 2, 3 appears in order on the wire.
- Present valid on exactly the frame-load edge with the buffer empty -> that frame is zeros with an underrun pulse; the pair is sent in the next frame.
- Assert reset_n = 0 at bitCnt 20 mid-frame with the buffer full -> the next edge gives all outputs 0, sampleReady = 0, buffer empty. After release, timing restarts identically to the first scenario.
